lut_cfg_shift: RTL and testbench



---
 rtl/lut_cfg_shift.sv | 105 ++++++++++
 tb/tb_lut_cfg_shift.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_shift.sv
// K-input LUT whose 2^K-bit table is shifted in serially (MSB first) into a shadow
// register and committed atomically. Optional readback ports under LUT_CFG_READBACK_EN.
module lut_cfg_shift #(
  parameter int               K    = 3,
  parameter logic [(1<<K)-1:0] INIT = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  input  logic                cfg_abort,
  output logic                cfg_busy,
  output logic                cfg_done,
`ifdef LUT_CFG_READBACK_EN
  output logic [(1<<K)-1:0]   cfg_rdata,
  output logic [K-1:0]        cfg_count,
`endif
  input  logic                lu_en,
  input  logic [K-1:0]        addr,
  output logic                z,
  output logic                z_valid
);
  localparam int N = 1 << K;
  localparam logic [K-1:0] LAST = K'(N - 1);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   active_q, active_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [K-1:0]   count_q, count_d;
  logic           done_q, done_d;
  logic           z_q, z_d;
  logic           zv_q, zv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= INIT;
      shadow_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      zv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      done_q   <= done_d;
      z_q      <= z_d;
      zv_q     <= zv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        // Abort takes precedence over a same-cycle final bit
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (cfg_valid) begin
          shadow_d = {shadow_q[N-2:0], cfg_bit};
          count_d  = count_q + 1'b1;
          if (count_q == LAST) begin
            active_d = shadow_d;
            state_d  = IDLE;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lookup reads active_q, so a commit-cycle lookup sees the old table
  always_comb begin
    z_d  = z_q;
    zv_d = lu_en;
    if (lu_en) z_d = active_q[addr];
  end

  assign cfg_busy = (state_q == LOAD);
  assign cfg_done = done_q;
  assign z        = z_q;
  assign z_valid  = zv_q;

`ifdef LUT_CFG_READBACK_EN
  assign cfg_rdata = active_q;
  assign cfg_count = count_q;
`endif

endmodule

// File: tb/tb_lut_cfg_shift.sv
// Scoreboard bench for lut_cfg_shift: a K=3 (INIT=A5) instance and a K=4 instance.
module tb_lut_cfg_shift;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // K=3 instance
  logic       a_start, a_valid, a_bit, a_abort, a_busy, a_done, a_lu, a_z, a_zv;
  logic [2:0] a_addr;
  // K=4 instance
  logic       b_start, b_valid, b_bit, b_abort, b_busy, b_done, b_lu, b_z, b_zv;
  logic [3:0] b_addr;
`ifdef LUT_CFG_READBACK_EN
  logic [7:0]  a_rdata;
  logic [2:0]  a_count;
  logic [15:0] b_rdata;
  logic [3:0]  b_count;
`endif

  lut_cfg_shift #(.K(3), .INIT(8'hA5)) dut_a (
    .clk(clk), .reset(reset),
    .cfg_start(a_start), .cfg_valid(a_valid), .cfg_bit(a_bit), .cfg_abort(a_abort),
    .cfg_busy(a_busy), .cfg_done(a_done),
`ifdef LUT_CFG_READBACK_EN
    .cfg_rdata(a_rdata), .cfg_count(a_count),
`endif
    .lu_en(a_lu), .addr(a_addr), .z(a_z), .z_valid(a_zv)
  );

  lut_cfg_shift #(.K(4), .INIT(16'h0000)) dut_b (
    .clk(clk), .reset(reset),
    .cfg_start(b_start), .cfg_valid(b_valid), .cfg_bit(b_bit), .cfg_abort(b_abort),
    .cfg_busy(b_busy), .cfg_done(b_done),
`ifdef LUT_CFG_READBACK_EN
    .cfg_rdata(b_rdata), .cfg_count(b_count),
`endif
    .lu_en(b_lu), .addr(b_addr), .z(b_z), .z_valid(b_zv)
  );

  int checks = 0;
  int errors = 0;
  logic      expq_a[$];
  logic      expq_b[$];
  logic [7:0]  mdl_a;   // hand-set expected active table of dut_a
  logic [15:0] mdl_b;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop an expectation whenever a lookup result is presented
  always @(negedge clk) begin
    if (a_zv) begin
      if (expq_a.size() == 0) chk("a_unexpected_z_valid", 16'd1, 16'd0);
      else chk("a_lookup_z", {15'd0, a_z}, {15'd0, expq_a.pop_front()});
    end
    if (b_zv) begin
      if (expq_b.size() == 0) chk("b_unexpected_z_valid", 16'd1, 16'd0);
      else chk("b_lookup_z", {15'd0, b_z}, {15'd0, expq_b.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One cycle of dut_a stimulus; a lookup pushes the model's current answer
  task automatic cyc_a(input logic st, input logic v, input logic b, input logic ab,
                       input logic le, input logic [2:0] a);
    a_start = st; a_valid = v; a_bit = b; a_abort = ab; a_lu = le; a_addr = a;
    if (le) expq_a.push_back(mdl_a[a]);
    tick();
    a_start = 0; a_valid = 0; a_abort = 0; a_lu = 0;
  endtask

  task automatic cyc_b(input logic st, input logic v, input logic b,
                       input logic le, input logic [3:0] a);
    b_start = st; b_valid = v; b_bit = b; b_lu = le; b_addr = a;
    if (le) expq_b.push_back(mdl_b[a]);
    tick();
    b_start = 0; b_valid = 0; b_lu = 0;
  endtask

  task automatic lookup_all_a();
    for (int i = 0; i < 8; i++) cyc_a(0, 0, 0, 0, 1, 3'(i));
    tick();
  endtask

  // Gap-free load of 8 bits MSB-first with busy/done checks
  task automatic load_a(input logic [7:0] val);
    cyc_a(1, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      chk("a_busy_during_load", {15'd0, a_busy}, 16'd1);
      cyc_a(0, 1, val[i], 0, 0, 0);
    end
    chk("a_busy_after_load", {15'd0, a_busy}, 16'd0);
    chk("a_done_pulse", {15'd0, a_done}, 16'd1);
    tick();
    chk("a_done_clears", {15'd0, a_done}, 16'd0);
  endtask

  logic [7:0] pat;

  initial begin
    a_start = 0; a_valid = 0; a_bit = 0; a_abort = 0; a_lu = 0; a_addr = 0;
    b_start = 0; b_valid = 0; b_bit = 0; b_abort = 0; b_lu = 0; b_addr = 0;
    mdl_a = 8'hA5; mdl_b = 16'h0000;
    reset = 1;
    tick(); tick();
    reset = 0;

    // Reset state
    chk("a_reset_busy", {15'd0, a_busy}, 16'd0);
    chk("a_reset_done", {15'd0, a_done}, 16'd0);
    chk("a_reset_z", {15'd0, a_z}, 16'd0);
    chk("a_reset_zv", {15'd0, a_zv}, 16'd0);
`ifdef LUT_CFG_READBACK_EN
    chk("a_reset_rdata", {8'd0, a_rdata}, 16'h00A5);
    chk("a_reset_count", {13'd0, a_count}, 16'd0);
`endif
    lookup_all_a();   // expects 1,0,1,0,0,1,0,1

    // XOR3 table
    load_a(8'h96);
    mdl_a = 8'h96;
    lookup_all_a();   // expects 0,1,1,0,1,0,0,1

    // 8'hFF with a 3-cycle gap after bit 4, lookups of addr 0 every cycle
    cyc_a(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc_a(0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("a_busy_in_gap", {15'd0, a_busy}, 16'd1);
      cyc_a(0, 0, 0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc_a(0, 1, 1, 0, 1, 0);
    cyc_a(0, 1, 1, 0, 1, 0);        // final bit: lookup still sees old table (0)
    mdl_a = 8'hFF;
    chk("a_done_after_gap_load", {15'd0, a_done}, 16'd1);
`ifdef LUT_CFG_READBACK_EN
    chk("a_rdata_after_commit", {8'd0, a_rdata}, 16'h00FF);
`endif
    cyc_a(0, 0, 0, 0, 1, 0);        // first post-commit lookup returns 1
    cyc_a(0, 0, 0, 0, 1, 2);
    tick();

    // Abort after 5 bits, then stray cfg_valid in IDLE
    cyc_a(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 0, 0, 0);
    cyc_a(0, 0, 0, 1, 0, 0);
    chk("a_busy_after_abort", {15'd0, a_busy}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      chk("a_no_done_idle", {15'd0, a_done}, 16'd0);
      cyc_a(0, 1, 0, 0, 0, 0);
    end
    chk("a_busy_idle_valid", {15'd0, a_busy}, 16'd0);
    lookup_all_a();   // still all ones

    // Abort on the same cycle as the 8th bit: no commit
    cyc_a(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc_a(0, 1, 0, 0, 0, 0);
    cyc_a(0, 1, 0, 1, 0, 0);
    chk("a_abort_wins_done", {15'd0, a_done}, 16'd0);
    chk("a_abort_wins_busy", {15'd0, a_busy}, 16'd0);
    lookup_all_a();   // still all ones

    // Fresh load after abort
    load_a(8'h3C);
    mdl_a = 8'h3C;
    lookup_all_a();

    // cfg_start reasserted mid-load is ignored
    pat = 8'h5A;
    cyc_a(1, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 5; i--) cyc_a(0, 1, pat[i], 0, 0, 0);
    cyc_a(1, 1, pat[4], 0, 0, 0);
    for (int i = 3; i >= 0; i--) cyc_a(0, 1, pat[i], 0, 0, 0);
    chk("a_restart_ignored_done", {15'd0, a_done}, 16'd1);
    mdl_a = 8'h5A;
    lookup_all_a();

    // Reset after bit 6 of a load
    cyc_a(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc_a(0, 1, 1, 0, 0, 0);
    reset = 1;
    tick();
    reset = 0;
    mdl_a = 8'hA5;
    chk("a_busy_after_reset", {15'd0, a_busy}, 16'd0);
    chk("a_z_after_reset", {15'd0, a_z}, 16'd0);
    cyc_a(0, 1, 1, 0, 0, 0);
    cyc_a(0, 1, 1, 0, 0, 0);
    chk("a_no_done_post_reset", {15'd0, a_done}, 16'd0);
    lookup_all_a();

    // K=4: load 16'h8000
    cyc_b(1, 0, 0, 0, 0);
    for (int i = 15; i >= 0; i--) cyc_b(0, 1, (i == 15), 0, 0);
    chk("b_done_pulse", {15'd0, b_done}, 16'd1);
`ifdef LUT_CFG_READBACK_EN
    chk("b_rdata_after_commit", b_rdata, 16'h8000);
`endif
    mdl_b = 16'h8000;
    for (int i = 0; i < 16; i++) cyc_b(0, 0, 0, 1, 4'(i));
    tick(); tick();

    chk("a_scoreboard_drained", 16'(expq_a.size()), 16'd0);
    chk("b_scoreboard_drained", 16'(expq_b.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule
